// File: rtl/axi4_pkg.sv
// AXI4 encodings and helpers shared by the Wishbone/AXI4 bridges.
package axi4_pkg;

    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI4_BURST_INCR  = 2'b01;

    // AxSIZE encoding for a full-width beat of data_width bits.
    function automatic logic [2:0] axi4_size(input int unsigned data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_width) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle (all five channels).
interface axi4_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4
);
    logic [ID_WIDTH-1:0]      awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awlock;
    logic [3:0]               awcache;
    logic [2:0]               awprot;
    logic                     awvalid;
    logic                     awready;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;
    logic [ID_WIDTH-1:0]      bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;
    logic [ID_WIDTH-1:0]      arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arlock;
    logic [3:0]               arcache;
    logic [2:0]               arprot;
    logic                     arvalid;
    logic                     arready;
    logic [ID_WIDTH-1:0]      rid;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle.
interface wb_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  adr;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic [DATA_WIDTH-1:0]     dat_r;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic                      ack;
    logic                      err;

    modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack, err);
    modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack, err);
endinterface

// File: rtl/wb_axi4_bridge.sv
// Single-outstanding Wishbone slave to AXI4 master bridge: each WB cycle
// becomes one single-beat AXI4 read or write.
module wb_axi4_bridge
    import axi4_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int AXI4_ID            = 0,
    parameter int WB_ADDRESS_WIDTH   = 32,
    parameter int WB_DATA_WIDTH      = 32
) (
    input logic    clk,
    input logic    rstn,
    wb_if.slave    wb_i,
    axi4_if.master axi_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam int         STRB_WIDTH = WB_DATA_WIDTH / 8;
    localparam logic [2:0] AX_SIZE    = axi4_size(AXI4_DATA_WIDTH);

    if (AXI4_DATA_WIDTH != WB_DATA_WIDTH) begin : g_width_check
        $error("wb_axi4_bridge: AXI4_DATA_WIDTH must equal WB_DATA_WIDTH");
    end

    logic [2:0]                    state;
    logic                          aw_done;
    logic                          w_done;
    logic                          aborted;
    logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
    logic [WB_DATA_WIDTH-1:0]      wdata_q;
    logic [WB_DATA_WIDTH-1:0]      rdata_q;
    logic [STRB_WIDTH-1:0]         sel_q;
    logic                          ack_q;
    logic                          err_q;

    logic req;
    logic live;
    logic aw_done_nxt;
    logic w_done_nxt;
    logic unused_ok;

    assign req         = wb_i.cyc && wb_i.stb;
    // A master that dropped CYC earlier must not be answered, even if it re-raised it.
    assign live        = req && !aborted;
    assign aw_done_nxt = aw_done || (axi_o.awvalid && axi_o.awready);
    assign w_done_nxt  = w_done  || (axi_o.wvalid  && axi_o.wready);
    assign unused_ok   = ^{axi_o.bid, axi_o.rid, axi_o.rlast};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            aborted <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // branch below sees the pre-edge values regardless of statement order.
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (state != IDLE && !req) aborted <= 1'b1;

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= AXI4_ADDRESS_WIDTH'(wb_i.adr);
                        wdata_q <= wb_i.dat_w;
                        sel_q   <= wb_i.sel;
                        aborted <= 1'b0;
                        state   <= wb_i.we ? WR : RD_ADDR;
                    end
                end
                WR: begin
                    aw_done <= aw_done_nxt;
                    w_done  <= w_done_nxt;
                    if (aw_done_nxt && w_done_nxt) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_o.bvalid) begin
                        ack_q <= live && (axi_o.bresp == AXI4_RESP_OKAY);
                        err_q <= live && (axi_o.bresp != AXI4_RESP_OKAY);
                        state <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (axi_o.arvalid && axi_o.arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (axi_o.rvalid) begin
                        rdata_q <= axi_o.rdata;
                        ack_q   <= live && (axi_o.rresp == AXI4_RESP_OKAY);
                        err_q   <= live && (axi_o.rresp != AXI4_RESP_OKAY);
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: outputs are continuous functions of registered state, so nothing here
    // can infer a latch and VALIDs drop exactly one edge after their handshake.
    assign axi_o.awid    = AXI4_ID_WIDTH'(AXI4_ID);
    assign axi_o.awaddr  = addr_q;
    assign axi_o.awlen   = 8'd0;
    assign axi_o.awsize  = AX_SIZE;
    assign axi_o.awburst = AXI4_BURST_INCR;
    assign axi_o.awlock  = 1'b0;
    assign axi_o.awcache = 4'd0;
    assign axi_o.awprot  = 3'd0;
    assign axi_o.awvalid = (state == WR) && !aw_done;

    assign axi_o.wdata   = wdata_q;
    assign axi_o.wstrb   = sel_q;
    assign axi_o.wlast   = 1'b1;
    assign axi_o.wvalid  = (state == WR) && !w_done;

    assign axi_o.bready  = (state == WR_RESP);

    assign axi_o.arid    = AXI4_ID_WIDTH'(AXI4_ID);
    assign axi_o.araddr  = addr_q;
    assign axi_o.arlen   = 8'd0;
    assign axi_o.arsize  = AX_SIZE;
    assign axi_o.arburst = AXI4_BURST_INCR;
    assign axi_o.arlock  = 1'b0;
    assign axi_o.arcache = 4'd0;
    assign axi_o.arprot  = 3'd0;
    assign axi_o.arvalid = (state == RD_ADDR);

    assign axi_o.rready  = (state == RD_DATA);

    assign wb_i.dat_r    = rdata_q;
    assign wb_i.ack      = ack_q;
    assign wb_i.err      = err_q;

endmodule

// File: doc/wb_axi4_bridge.md
# wb_axi4_bridge

Single-outstanding bridge from a classic Wishbone slave port to an AXI4 master port. It lets a Wishbone-side initiator (debug master, WB-native DMA, test driver) reach AXI4 memory such as the boot ROM and SRAM through the AXI4 interconnect. It is the counterpart of `axi4_wb_bridge`, carrying transactions in the opposite direction. Each Wishbone cycle becomes exactly one single-beat AXI4 read or write.

## Interface
Parameters:
- AXI4_ADDRESS_WIDTH, 32, AXI address width
- AXI4_DATA_WIDTH, 32, AXI data width; must equal WB_DATA_WIDTH (elaboration error otherwise)
- AXI4_ID_WIDTH, 4, AXI ID width
- AXI4_ID, 0, fixed value driven on AWID and ARID
- WB_ADDRESS_WIDTH, 32, WB address width
- WB_DATA_WIDTH, 32, WB data width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset
- wb_i  wb_if.slave  -  ADR, DAT_W, DAT_R, CYC, STB, SEL, WE, ACK, ERR
- axi_o  axi4_if.master  -  AW/W/B/AR/R channels

## Operation
- FSM states: IDLE, WR (AW+W pending), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: when CYC&STB, capture ADR, DAT_W, SEL, WE.
  - WE=1 → WR, driving AWVALID=WVALID=1.
  - WE=0 → RD_ADDR, driving ARVALID=1.
- Address mapping: ADR is zero-extended or truncated to AXI4_ADDRESS_WIDTH.
- Fixed AXI attributes: AxLEN=0; AxSIZE=log2(bytes per word); AxBURST=INCR; AxPROT=0; AxCACHE=0; AxLOCK=0.
- Write data: WSTRB=SEL, WLAST=1.
- WR: AW and W complete independently.
  - Internal flags aw_done/w_done are set on their respective handshakes.
  - The corresponding VALID drops the cycle after its handshake.
  - Both done (including a same-cycle handshake of both) → WR_RESP.
- WR_RESP: BREADY=1. On BVALID, latch err = (BRESP != OKAY) → RESP.
- RD_ADDR: on ARVALID&ARREADY → RD_DATA.
- RD_DATA: RREADY=1. On RVALID, latch RDATA into DAT_R and err = (RRESP != OKAY) → RESP.
  - RLAST is ignored (always single beat).
- RESP: if CYC&STB still asserted, pulse ACK=!err or ERR=err for exactly one cycle. Always → IDLE.
- CYC dropped mid-transaction (abort):
  - The AXI transaction still completes fully; no AXI channel is abandoned.
  - The response is discarded: no ACK or ERR.
  - DAT_R still updates on a read.
- Back-to-back: a new request is accepted in IDLE the cycle after RESP. An STB held high through RESP is never re-captured as a second request.
- DAT_R holds its last read value until the next read completes.
- Reset, including mid-transaction:
  - All VALID/READY outputs go to 0, ACK=ERR=0, DAT_R=0, FSM → IDLE.
  - All AxADDR/WDATA registers go to 0.
  - Mid-operation reset is legal only as a system-wide reset.

## Timing
- Request sampled at edge 0 (IDLE). AWVALID/WVALID/ARVALID high after edge 0.
- Zero-wait write slave (READY high, BVALID the cycle after the AW/W handshake):
  - BREADY high after edge 1.
  - B handshake at edge 2.
  - ACK high between edges 2 and 3.
  - Total STB→ACK: 3 cycles.
- Zero-wait read slave: STB→ACK is also 3 cycles.
- ACK/ERR are registered outputs, one cycle wide, and never both high.
- Each added AXI wait cycle adds exactly one cycle of latency.
- VALID stays stable until its handshake; address, data and strobe never change while VALID=1.

## Structure
- Shared package axi4_pkg holds:
  - resp constants AXI4_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - burst constant AXI4_BURST_INCR
  - a size-from-width function
- The FSM state enum is local to the module.
- No sub-module; a single flat module of roughly 180 lines.

## Test plan
- Single write: ADR=0x20000010, DAT_W=0xDEADBEEF, SEL=0xF, zero-wait AXI SRAM → AWADDR=0x20000010, WDATA=0xDEADBEEF, WSTRB=0xF, WLAST=1, ACK exactly 3 cycles after STB. A following read returns 0xDEADBEEF with ACK.
- Byte write SEL=0x4, DAT_W=0x00AB0000 to a word holding 0x11223344 → WSTRB=0x4; readback 0x11AB3344.
- Skewed write handshake: AWREADY delayed 4 cycles, WREADY immediate, then the reverse → single AW and W handshakes each, WVALID/AWVALID drop after their own handshake, one ACK.
- Error response: read ADR=0x30000000 decoded by the interconnect as DECERR → ERR one cycle, ACK=0. A write to the same address → ERR one cycle.
- Abort: CYC deasserted 1 cycle after STB with ARREADY stalled 5 cycles → AR and R still complete (RREADY asserted), no ACK/ERR, FSM back in IDLE. The next read completes normally.
- Reset mid-read in RD_DATA → all VALID/READY, ACK, ERR and DAT_R are 0 the cycle after the rstn edge. The next STB after reset release starts a clean ARVALID.
